tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux4_pkg.sv | 18 +
 rtl/tdm_slot_ctr.sv | 27 ++
 rtl/tdm_demux4.sv | 139 +++++++++++++
 tb/tb_tdm_demux4.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux4_pkg.sv
// Shared FSM states and slot constants for the 4-slot TDM demultiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tdm_demux4_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int SLOT_W = 2;

    localparam logic [SLOT_W-1:0] SLOT0 = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT1 = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT2 = 2'd2;
    localparam logic [SLOT_W-1:0] SLOT3 = 2'd3;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter: advance with 3->0 wrap, load-to-1 on frame start, clear.
// Latency: one edge from control to count.
// Backpressure: none; the caller only asserts controls on qualified sample cycles.
module tdm_slot_ctr
    import tdm_demux4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              load_one,
    input  logic              clr,
    output logic [SLOT_W-1:0] slot
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= SLOT0;
        end else if (clr) begin
            slot <= SLOT0;
        end else if (load_one) begin
            slot <= SLOT1;
        end else if (adv) begin
            slot <= slot + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Demultiplexes a 4-slot TDM stream into four registered channels with sync tracking.
// Latency: one edge from the slot-3 sample to y1..y4 and FRAME_VALID.
// Backpressure: none; EN low freezes all state, FRAME_VALID/ERR are single-cycle pulses.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             SYNC,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic             FRAME_VALID,
    output logic             LOCK,
    output logic             ERR
);

    state_t             state, state_nxt;
    logic [SLOT_W-1:0]  slot;
    logic               ctr_adv, ctr_load1, ctr_clr;
    logic               stg0_wr, stg_mid_wr, out_load;
    logic               fv_nxt, err_nxt;
    logic [WIDTH-1:0]   stg0, stg1, stg2;

    tdm_slot_ctr u_slot_ctr (
        .clk      (CLK),
        .rst_n    (RST_N),
        .adv      (ctr_adv),
        .load_one (ctr_load1),
        .clr      (ctr_clr),
        .slot     (slot)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ctr_adv    = 1'b0;
        ctr_load1  = 1'b0;
        ctr_clr    = 1'b0;
        stg0_wr    = 1'b0;
        stg_mid_wr = 1'b0;
        out_load   = 1'b0;
        fv_nxt     = 1'b0;
        err_nxt    = 1'b0;
        if (EN) begin
            case (state)
                HUNT: begin
                    if (SYNC) begin
                        stg0_wr   = 1'b1;
                        ctr_load1 = 1'b1;
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (SYNC) begin
                        // A sync anywhere but slot 0 restarts the frame and flags it.
                        stg0_wr   = 1'b1;
                        ctr_load1 = 1'b1;
                        err_nxt   = (slot != SLOT0);
                    end else begin
                        case (slot)
                            SLOT0: begin
                                err_nxt   = 1'b1;
                                ctr_clr   = 1'b1;
                                state_nxt = HUNT;
                            end
                            SLOT1, SLOT2: begin
                                stg_mid_wr = 1'b1;
                                ctr_adv    = 1'b1;
                            end
                            SLOT3: begin
                                out_load = 1'b1;
                                fv_nxt   = 1'b1;
                                ctr_adv  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stg0 <= '0;
            stg1 <= '0;
            stg2 <= '0;
        end else begin
            if (stg0_wr) begin
                stg0 <= DIN;
            end
            if (stg_mid_wr) begin
                if (slot == SLOT1) begin
                    stg1 <= DIN;
                end else begin
                    stg2 <= DIN;
                end
            end
        end
    end

    // Slot 3 bypasses staging so the whole frame lands in one edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            y4          <= '0;
            FRAME_VALID <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            if (out_load) begin
                y1 <= stg0;
                y2 <= stg1;
                y3 <= stg2;
                y4 <= DIN;
            end
            FRAME_VALID <= fv_nxt;
            ERR         <= err_nxt;
        end
    end

    assign LOCK = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus randomized traffic
// checked against a queue-based frame assembly model.
module tb_tdm_demux4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       EN = 1'b0;
    logic       SYNC = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic [7:0] y1, y2, y3, y4;
    logic       FRAME_VALID, LOCK, ERR;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame being collected, lock flag, last delivered frame, pulses.
    logic [7:0] m_q[$];
    logic [7:0] m_y[4];
    logic       m_locked, m_fv, m_err;

    tdm_demux4 #(.WIDTH(8)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .EN          (EN),
        .SYNC        (SYNC),
        .DIN         (DIN),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .y4          (y4),
        .FRAME_VALID (FRAME_VALID),
        .LOCK        (LOCK),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 4; i++) m_y[i] = 8'h00;
        m_locked = 1'b0;
        m_fv     = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic sync, input logic [7:0] din);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (en) begin
            if (!m_locked) begin
                if (sync) begin
                    m_q.delete();
                    m_q.push_back(din);
                    m_locked = 1'b1;
                end
            end else if (sync) begin
                if (m_q.size() != 0) m_err = 1'b1;
                m_q.delete();
                m_q.push_back(din);
            end else if (m_q.size() == 0) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_q.push_back(din);
                if (m_q.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_y[i] = m_q[i];
                    m_fv = 1'b1;
                    m_q.delete();
                end
            end
        end
    endtask

    function automatic logic [34:0] exp_vec();
        return {m_y[0], m_y[1], m_y[2], m_y[3], m_fv, m_locked, m_err};
    endfunction

    // Drive at the falling edge, let the rising edge happen, return at the next falling edge.
    task automatic drive(input logic en, input logic sync, input logic [7:0] din);
        EN   = en;
        SYNC = sync;
        DIN  = din;
        @(posedge CLK);
        model_step(en, sync, din);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        model_reset();
        RST_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            EN = 1'b1; SYNC = i[0]; DIN = d;
            @(negedge CLK);
            n_tests++;
            if ({y1, y2, y3, y4, FRAME_VALID, LOCK, ERR} !== 35'h0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, {y1, y2, y3, y4, FRAME_VALID, LOCK, ERR});
            end
        end
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'($urandom));
            n_tests++;
            if ({y1, y2, y3, y4, FRAME_VALID, LOCK, ERR} !== 35'h0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=0", i, {y1, y2, y3, y4, FRAME_VALID, LOCK, ERR});
            end
        end
    endtask

    task automatic test_nominal();
        logic [7:0] s[4];
        s[0] = 8'h11; s[1] = 8'h22; s[2] = 8'h33; s[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0), s[i]);
            n_tests++;
            if ({y1, y2, y3, y4, FRAME_VALID, LOCK, ERR} !== exp_vec()) begin
                n_fail++;
                $display("FAIL nominal_step%0d got=%h exp=%h", i, {y1, y2, y3, y4, FRAME_VALID, LOCK, ERR}, exp_vec());
            end
        end
        n_tests++;
        if ({y1, y2, y3, y4, FRAME_VALID, LOCK, ERR} !== {32'h11223344, 3'b110}) begin
            n_fail++;
            $display("FAIL nominal_frame got=%h exp=%h", {y1, y2, y3, y4, FRAME_VALID, LOCK, ERR}, {32'h11223344, 3'b110});
        end
        drive(1'b0, 1'b0, 8'h00);
        n_tests++;
        if (FRAME_VALID !== 1'b0 || LOCK !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_fv_pulse got fv=%b lock=%b exp fv=0 lock=1", FRAME_VALID, LOCK);
        end
    endtask

    task automatic test_en_gap();
        drive(1'b1, 1'b1, 8'hA1);
        drive(1'b1, 1'b0, 8'hA2);
        drive(1'b1, 1'b0, 8'hA3);
        drive(1'b1, 1'b0, 8'hA4);
        n_tests++;
        if ({y1, y2, y3, y4} !== 32'hA1A2A3A4) begin
            n_fail++;
            $display("FAIL gap_preframe got=%h exp=a1a2a3a4", {y1, y2, y3, y4});
        end
        drive(1'b1, 1'b1, 8'h11);
        drive(1'b1, 1'b0, 8'h22);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom), 8'($urandom));
            n_tests++;
            if ({y1, y2, y3, y4, FRAME_VALID, LOCK, ERR} !== {32'hA1A2A3A4, 3'b010}) begin
                n_fail++;
                $display("FAIL gap_hold cyc=%0d got=%h exp=%h", i, {y1, y2, y3, y4, FRAME_VALID, LOCK, ERR}, {32'hA1A2A3A4, 3'b010});
            end
        end
        drive(1'b1, 1'b0, 8'h33);
        drive(1'b1, 1'b0, 8'h44);
        n_tests++;
        if ({y1, y2, y3, y4, FRAME_VALID, LOCK, ERR} !== {32'h11223344, 3'b110}) begin
            n_fail++;
            $display("FAIL gap_frame got=%h exp=%h", {y1, y2, y3, y4, FRAME_VALID, LOCK, ERR}, {32'h11223344, 3'b110});
        end
    endtask

    task automatic test_early_sync();
        drive(1'b1, 1'b1, 8'hAA);
        drive(1'b1, 1'b0, 8'hBB);
        drive(1'b1, 1'b1, 8'h01);
        n_tests++;
        if ({ERR, FRAME_VALID, LOCK} !== 3'b101) begin
            n_fail++;
            $display("FAIL early_sync_err got err/fv/lock=%b exp=101", {ERR, FRAME_VALID, LOCK});
        end
        drive(1'b1, 1'b0, 8'h02);
        drive(1'b1, 1'b0, 8'h03);
        n_tests++;
        if ({y1, y2, y3, y4, FRAME_VALID} !== {32'h11223344, 1'b0}) begin
            n_fail++;
            $display("FAIL early_sync_nofv got=%h exp=%h", {y1, y2, y3, y4, FRAME_VALID}, {32'h11223344, 1'b0});
        end
        drive(1'b1, 1'b0, 8'h04);
        n_tests++;
        if ({y1, y2, y3, y4, FRAME_VALID, LOCK, ERR} !== {32'h01020304, 3'b110}) begin
            n_fail++;
            $display("FAIL early_sync_frame got=%h exp=%h", {y1, y2, y3, y4, FRAME_VALID, LOCK, ERR}, {32'h01020304, 3'b110});
        end
    endtask

    task automatic test_missing_sync();
        drive(1'b1, 1'b0, 8'h99);
        n_tests++;
        if ({y1, y2, y3, y4, FRAME_VALID, LOCK, ERR} !== {32'h01020304, 3'b001}) begin
            n_fail++;
            $display("FAIL missing_sync got=%h exp=%h", {y1, y2, y3, y4, FRAME_VALID, LOCK, ERR}, {32'h01020304, 3'b001});
        end
        drive(1'b1, 1'b0, 8'h98);
        n_tests++;
        if ({ERR, LOCK} !== 2'b00) begin
            n_fail++;
            $display("FAIL missing_sync_hunt got err/lock=%b exp=00", {ERR, LOCK});
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b1, 8'h55);
        drive(1'b1, 1'b0, 8'h66);
        #2 RST_N = 1'b0;
        #1;
        n_tests++;
        if ({y1, y2, y3, y4, FRAME_VALID, LOCK, ERR} !== 35'h0) begin
            n_fail++;
            $display("FAIL mid_reset_async got=%h exp=0", {y1, y2, y3, y4, FRAME_VALID, LOCK, ERR});
        end
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        drive(1'b1, 1'b0, 8'h77);
        n_tests++;
        if (LOCK !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_nolock got lock=%b exp=0", LOCK);
        end
        drive(1'b1, 1'b1, 8'h55);
        drive(1'b1, 1'b0, 8'h66);
        drive(1'b1, 1'b0, 8'h77);
        drive(1'b1, 1'b0, 8'h88);
        n_tests++;
        if ({y1, y2, y3, y4, FRAME_VALID, LOCK, ERR} !== {32'h55667788, 3'b110}) begin
            n_fail++;
            $display("FAIL mid_reset_frame got=%h exp=%h", {y1, y2, y3, y4, FRAME_VALID, LOCK, ERR}, {32'h55667788, 3'b110});
        end
    endtask

    task automatic test_random();
        logic en, sync;
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 9) < 8);
            sync = ($urandom_range(0, 4) == 0);
            drive(en, sync, 8'($urandom));
            n_tests++;
            if ({y1, y2, y3, y4, FRAME_VALID, LOCK, ERR} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, {y1, y2, y3, y4, FRAME_VALID, LOCK, ERR}, exp_vec());
            end
            n_tests++;
            if (FRAME_VALID === 1'b1 && ERR === 1'b1) begin
                n_fail++;
                $display("FAIL random_fv_err cyc=%0d got fv=1 err=1 exp not both", i);
            end
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_nominal();
        test_en_gap();
        test_early_sync();
        test_missing_sync();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
